bit_serializer: RTL and testbench

Parallel-to-serial stage feeding the sequence-detector FSM's single-bit input `i`. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `bit_out`, with a `bit_valid` qualifier and a last-bit flag. Back-to-back words stream with no idle gap, so the downstream detector sees a continuous bit stream across word boundaries.

---
 rtl/bit_serializer_pkg.sv | 24 ++
 rtl/ser_bit_counter.sv | 28 ++
 rtl/bit_serializer.sv | 99 +++++++++
 tb/tb_bit_serializer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing for bit_serializer; also imported by the detector bench.
// BIT_SERIALIZER_PARITY_EN appends one even-parity bit to every frame.
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_WIDTH_DEFAULT = 8;
  localparam int SER_CNT_W_DEFAULT = $clog2(SER_WIDTH_DEFAULT + 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int SER_PARITY_BITS = 1;
`else
  localparam int SER_PARITY_BITS = 0;
`endif

  // Wide enough to hold FL-1 even when the parity bit extends the frame.
  function automatic int ser_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit position counter for bit_serializer: clear has priority over enable,
// and o_tc flags the terminal bit of the frame.
module ser_bit_counter #(
  parameter int CNT_W = 4,
  parameter int TC    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_W'(TC));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the sequence detector; streams words back to
// back with no gap. Optional parity bit via BIT_SERIALIZER_PARITY_EN.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             busy
);

  localparam int CNT_W = ser_cnt_width(WIDTH);
  localparam int FL    = WIDTH + SER_PARITY_BITS;

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic             w_tc;
  logic             w_busy;
  logic             w_last;
  logic             w_accept;
  logic             w_bit;

  assign w_busy     = (r_state == ST_SHIFT);
  assign w_last     = w_busy && w_tc;
  assign load_ready = !w_busy || w_last;
  assign w_accept   = load_valid && load_ready;

  // Clearing on every last bit covers both the reload and the return to idle.
  ser_bit_counter #(
    .CNT_W (CNT_W),
    .TC    (FL - 1)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept || w_last),
    .i_en  (w_busy),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last && !w_accept) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
    end else if (w_accept) begin
      r_shift <= data_in;
    end else if (w_busy) begin
      r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
    end
  end

`ifdef BIT_SERIALIZER_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^data_in;
    end
  end

  // The parity bit is by construction the last bit of the frame.
  assign w_bit = w_last ? r_parity : (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
`else
  assign w_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
`endif

  assign bit_out   = w_busy ? w_bit : IDLE_LEVEL;
  assign bit_valid = w_busy;
  assign bit_last  = w_last;
  assign busy      = w_busy;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances share stimulus;
// expected bits are queued at handshake and popped each cycle the DUT should emit.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  localparam int   W    = 8;
  localparam int   FL   = W + SER_PARITY_BITS;
  localparam logic IDLE = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] data_in = '0;

  logic m_ready, m_out, m_valid, m_last, m_busy;
  logic l_ready, l_out, l_valid, l_last, l_busy;

  logic [1:0] qm[$];
  logic [1:0] ql[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(m_ready), .bit_out(m_out), .bit_valid(m_valid),
    .bit_last(m_last), .busy(m_busy)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(l_ready), .bit_out(l_out), .bit_valid(l_valid),
    .bit_last(l_last), .busy(l_busy)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s {valid,out,last,busy,ready} observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back({d[W-1-i], 1'(i == FL - 1)});
      ql.push_back({d[i], 1'(i == FL - 1)});
    end
    if (SER_PARITY_BITS != 0) begin
      qm.push_back({^d, 1'b1});
      ql.push_back({^d, 1'b1});
    end
  endtask

  task automatic tick();
    logic [1:0] e;
    logic [4:0] exp;
    @(negedge clk);
    if (qm.size() > 0) begin
      e = qm.pop_front();
      exp = {1'b1, e[1], e[0], 1'b1, 1'(qm.size() == 0)};
    end else begin
      exp = {1'b0, IDLE, 1'b0, 1'b0, 1'b1};
    end
    chk("msb_cycle", {m_valid, m_out, m_last, m_busy, m_ready}, exp);
    if (ql.size() > 0) begin
      e = ql.pop_front();
      exp = {1'b1, e[1], e[0], 1'b1, 1'(ql.size() == 0)};
    end else begin
      exp = {1'b0, IDLE, 1'b0, 1'b0, 1'b1};
    end
    chk("lsb_cycle", {l_valid, l_out, l_last, l_busy, l_ready}, exp);
  endtask

  // Inputs change at the falling edge; acceptance follows the model's ready.
  task automatic step(input logic v, input logic [W-1:0] d, output bit acc);
    load_valid = v;
    data_in    = d;
    acc        = v && (qm.size() == 0);
    if (acc) push_word(d);
    tick();
  endtask

  task automatic send(input logic [W-1:0] d);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) step(1'b1, d, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, '0, acc);
  endtask

  initial begin
    bit acc;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    send(8'hD0);
    idle(FL + 1);
    send(8'hB0);
    idle(FL + 1);

    send(8'hAA);
    send(8'h55);
    idle(FL + 1);

    send(8'hD0);
    idle(2);
    step(1'b1, 8'hFF, acc);
    idle(FL + 1);

    send(8'hFF);
    idle(4);
    #2 rst = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    chk("msb_async_reset", {m_valid, m_out, m_last, m_busy, m_ready}, {1'b0, IDLE, 1'b0, 1'b0, 1'b1});
    chk("lsb_async_reset", {l_valid, l_out, l_last, l_busy, l_ready}, {1'b0, IDLE, 1'b0, 1'b0, 1'b1});
    tick();
    rst = 1'b1;
    send(8'h0F);
    idle(FL + 1);

    send(8'h07);
    idle(FL + 1);
    send(8'h03);
    idle(FL + 1);

    repeat (4) send(W'($urandom));
    idle(FL + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
